mag_calc_seq: RTL
=================

// Module: mag_calc_seq
// PURPOSE
// - Operand sequencer and result scheduler for the magnitude calculator datapath.
// - Collects a signed (x, y) operand pair over an 8-bit valid/ready byte stream.
// - Runs the selected magnitude operation: single-cycle, or iterative for L2.
// - Holds the result on a valid/ready output until it is consumed.
// - Sits between the tile's ui_in/uio pins and the output pins of the top-level calculator.
// PARAMETERS
// - W        8  operand width; operands are signed two's complement.
// - CNT_W    8  width of the done_count result counter.
// PORTS
// - clk         in   1       single clock, rising edge.
// - rst         in   1       asynchronous reset, active-high; all state cleared immediately.
// - abort       in   1       synchronous abort: drop the pair or operation in progress.
// - in_valid    in   1       in_data/in_op valid.
// - in_ready    out  1       sequencer accepts a byte this cycle.
// - in_data     in   W       operand byte: first beat x, second beat y.
// - in_op       in   2       op select, sampled on the x beat only.
// - out_valid   out  1       out_data valid; held until out_ready.
// - out_ready   in   1       consumer accepts the result.
// - out_data    out  W+1     unsigned magnitude.
// - out_op      out  2       op that produced out_data.
// - busy        out  1       high in any state other than LOAD_X.
// - done_count  out  CNT_W   count of results consumed; wraps.
// BEHAVIOUR
// - Ops (unsigned, width W+1, no overflow possible):
//   - 0 L1   = |x|+|y|
//   - 1 LINF = max(|x|,|y|)
//   - 2 L2   = floor(sqrt(x^2+y^2))
//   - 3 AMBM = max + (min>>1), with max/min taken over |x|,|y|
// - |-2^(W-1)| = 2^(W-1), computed without wrap.
// - FSM states: LOAD_X -> LOAD_Y -> CALC -> DONE -> LOAD_X.
//   - LOAD_X: in_ready=1. On the handshake, latch x and in_op; go to LOAD_Y.
//   - LOAD_Y: in_ready=1. On the handshake, latch y; go to CALC.
//   - CALC: in_ready=0.
//     - Ops 0/1/3: exactly 1 cycle.
//     - L2: 1 cycle forms the 2W-bit sum of squares, then W restoring-sqrt iterations
//       (one result bit per cycle, MSB first). Total W+1 cycles.
//     - Result registered; go to DONE.
//   - DONE: out_valid=1; out_data/out_op stable while out_ready=0.
//     - On the handshake: go to LOAD_X and increment done_count (wraps 2^CNT_W-1 -> 0).
// - Latency, y handshake -> out_valid rising: 2 cycles for ops 0/1/3, W+2 cycles for L2.
// - Throughput: in_ready rises the cycle after the output handshake (one bubble).
// - No combinational path from in_valid/out_ready to in_ready/out_valid.
// - abort (any state) -> next state LOAD_X.
//   - Drops the partial pair, the computation or an unconsumed result.
//   - done_count is unchanged.
//   - abort beats a simultaneous in/out handshake: the beat is not taken and not counted.
// - Reset values:
//   - state LOAD_X; in_ready=1, out_valid=0, out_data=0, out_op=0, busy=0, done_count=0.
//   - All operand and sqrt registers 0.
// - Reset mid-CALC: discards the operation; no out_valid afterwards.
// - in_op on the y beat is ignored. in_data is ignored when in_ready=0.
// STRUCTURE
// - Package mag_calc_pkg:
//   - op_e enum (OP_L1, OP_LINF, OP_L2, OP_AMBM).
//   - state_e enum (LOAD_X, LOAD_Y, CALC, DONE).
//   - Default W.
// - Sub-module mag_isqrt:
//   - Iterative restoring square root.
//   - Ports: clk, rst, start, radicand[2W-1:0], done, root[W-1:0].
//   - Flush on abort.
//   - The controller starts it and waits for done.
// - Abs, max/min, L1 and AMBM stay inline in mag_calc_seq.
// TESTING
// 1. Reset with rst high mid-stream -> in_ready=1, out_valid=0, done_count=0, busy=0.
// 2. Op 0 (L1), x=-3, y=4 -> out_data=7 exactly 2 cycles after the y beat.
//    Op 1 (LINF), x=3, y=-7 -> 7. Op 3 (AMBM), x=3, y=4 -> 5.
// 3. Op 2 (L2), x=3, y=4 -> out_data=5 at W+2=10 cycles after the y beat.
//    Op 2, x=-128, y=-128 -> 181.
//    Op 0, x=-128, y=-128 -> 256. Op 3, x=-128, y=-128 -> 192.
// 4. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//    -> out_valid and out_data held; in_ready=0; done_count increments once on release.
// 5. abort on the 4th L2 CALC cycle -> LOAD_X next cycle; no out_valid; done_count unchanged.
//    abort together with an out handshake -> done_count unchanged.
// 6. 256 back-to-back L1 results -> done_count wraps to 0; in_ready gap of exactly 1 cycle
//    after each output handshake.

Source files
------------

// File: rtl/mag_calc_pkg.sv
// Shared types and default widths for the magnitude calculator sequencer.
package mag_calc_pkg;

  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_L1   = 2'd0,
    OP_LINF = 2'd1,
    OP_L2   = 2'd2,
    OP_AMBM = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mag_isqrt.sv
// Iterative restoring integer square root: one root bit per cycle, MSB first.
module mag_isqrt import mag_calc_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic           done,
  output logic [W-1:0]   root
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] rad_q, rad_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   root_q, root_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;

  logic [W+2:0]   rem_sh, trial;
  logic           fits;
  logic [W:0]     rem_nxt;
  logic [W-1:0]   root_nxt;

  assign rem_sh   = {rem_q, rad_q[2*W-1 -: 2]};
  assign trial    = {1'b0, root_q, 2'b01};
  assign fits     = rem_sh >= trial;
  assign rem_nxt  = fits ? (W+1)'(rem_sh - trial) : rem_sh[W:0];
  assign root_nxt = {root_q[W-2:0], fits};

  // done flags the final iteration cycle; root already includes that last bit
  assign done = run_q && (cnt_q == CW'(W-1));
  assign root = root_nxt;

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (flush) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      rad_d  = {rad_q[2*W-3:0], 2'b00};
      rem_d  = rem_nxt;
      root_d = root_nxt;
      cnt_d  = cnt_q + CW'(1);
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/mag_calc_seq.sv
// Operand sequencer and result scheduler for the magnitude calculator.
//   state  | meaning
//   LOAD_X | waiting for the x beat (and op)
//   LOAD_Y | waiting for the y beat
//   CALC   | computing; L2 runs the iterative square root
//   DONE   | result held on the output until consumed
module mag_calc_seq import mag_calc_pkg::*; #(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_data,
  output logic [1:0]       out_op,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  state_e           state_q, state_d;
  logic [W-1:0]     x_q, x_d, y_q, y_d;
  op_e              op_q, op_d, res_op_q, res_op_d;
  logic [W:0]       res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             l2_run_q, l2_run_d;

  logic [W:0]       ax, ay, mx, mn, fast_res;
  logic [2*W-1:0]   ax_w, ay_w, sq_sum;
  logic             sq_start, sq_done;
  logic [W-1:0]     sq_root;

  // sign-extend to W+1 before negating so -2^(W-1) maps to 2^(W-1)
  assign ax = x_q[W-1] ? ((W+1)'(0) - {1'b1, x_q}) : {1'b0, x_q};
  assign ay = y_q[W-1] ? ((W+1)'(0) - {1'b1, y_q}) : {1'b0, y_q};
  assign mx = (ax >= ay) ? ax : ay;
  assign mn = (ax >= ay) ? ay : ax;

  assign ax_w   = {{(W-1){1'b0}}, ax};
  assign ay_w   = {{(W-1){1'b0}}, ay};
  assign sq_sum = ax_w * ax_w + ay_w * ay_w;

  always_comb begin
    fast_res = '0;
    case (op_q)
      OP_L1:   fast_res = ax + ay;
      OP_LINF: fast_res = mx;
      OP_AMBM: fast_res = mx + (mn >> 1);
      default: fast_res = '0;
    endcase
  end

  mag_isqrt #(.W(W)) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .start    (sq_start),
    .radicand (sq_sum),
    .done     (sq_done),
    .root     (sq_root)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    op_d     = op_q;
    res_d    = res_q;
    res_op_d = res_op_q;
    cnt_d    = cnt_q;
    l2_run_d = l2_run_q;
    sq_start = 1'b0;
    if (abort) begin
      state_d = LOAD_X;
    end else begin
      case (state_q)
        LOAD_X: if (in_valid) begin
          x_d     = in_data;
          op_d    = op_e'(in_op);
          state_d = LOAD_Y;
        end
        LOAD_Y: if (in_valid) begin
          y_d      = in_data;
          l2_run_d = 1'b0;
          state_d  = CALC;
        end
        CALC: begin
          if (op_q != OP_L2) begin
            res_d    = fast_res;
            res_op_d = op_q;
            state_d  = DONE;
          end else if (!l2_run_q) begin
            sq_start = 1'b1;
            l2_run_d = 1'b1;
          end else if (sq_done) begin
            res_d    = {1'b0, sq_root};
            res_op_d = op_q;
            state_d  = DONE;
          end
        end
        DONE: if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = LOAD_X;
        end
        default: state_d = LOAD_X;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD_X;
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= OP_L1;
      res_q    <= '0;
      res_op_q <= OP_L1;
      cnt_q    <= '0;
      l2_run_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      op_q     <= op_d;
      res_q    <= res_d;
      res_op_q <= res_op_d;
      cnt_q    <= cnt_d;
      l2_run_q <= l2_run_d;
    end
  end

  assign in_ready   = (state_q == LOAD_X) || (state_q == LOAD_Y);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != LOAD_X);
  assign out_data   = res_q;
  assign out_op     = res_op_q;
  assign done_count = cnt_q;

endmodule
